// File: rtl/reg_scoreboard_pkg.sv
// Shared hazard definitions for the issue scoreboard and EX-stage forwarding.
// Register address width, file size and forwarding source encodings.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NREGS      = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [1:0] {
        FWD_NONE   = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2,
        FWD_WB     = 2'd3
    } fwd_sel_e;

    function automatic logic is_x0(input reg_addr_t a);
        return a == '0;
    endfunction

endpackage

// File: rtl/reg_scoreboard_addr_decoder.sv
// Register address to one-hot mask decoder; all-zero mask when disabled.
// Used for both the set and the clear side of the busy vector.
module addr_decoder #(
    parameter int N  = 32,
    parameter int AW = 5
) (
    input  logic          en_i,
    input  logic [AW-1:0] addr_i,
    output logic [N-1:0]  mask_o
);

    always_comb begin
        mask_o = '0;
        if (en_i) begin
            mask_o[addr_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Producer-side scoreboard: tracks destinations of long-latency ops in flight
// and stalls ID on RAW/WAW against them or when too many are outstanding.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int  NREGS       = reg_scoreboard_pkg::NREGS,
    parameter int  MAX_PENDING = 4,
    localparam int CNT_W       = $clog2(MAX_PENDING + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  reg_addr_t        id_rs1_addr,
    input  logic             id_rs1_used,
    input  reg_addr_t        id_rs2_addr,
    input  logic             id_rs2_used,
    input  reg_addr_t        id_rd_addr,
    input  logic             id_rd_we,
    input  logic             id_long_op,
    input  logic             ex_ready,
    input  logic             flush,
    input  logic             wb_valid,
    input  reg_addr_t        wb_rd_addr,
    output logic             stall_id,
    output logic             id_issue,
    output logic [NREGS-1:0] busy,
    output logic [CNT_W-1:0] pending_count,
    output logic             err
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             err_q;
    logic             err_d;

    logic             clr;
    logic             set;
    logic             wb_bad;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] busy_eff;
    logic [CNT_W:0]   cnt_eff;
    logic             raw;
    logic             waw;
    logic             full;
    logic             rd_tracked;

    // Only a writeback to a register we actually track may release it.
    assign clr    = wb_valid && !is_x0(wb_rd_addr) && busy_q[wb_rd_addr];
    assign wb_bad = wb_valid && (is_x0(wb_rd_addr) || !busy_q[wb_rd_addr]);

    addr_decoder #(
        .N  (NREGS),
        .AW (REG_ADDR_W)
    ) u_clr_dec (
        .en_i   (clr),
        .addr_i (wb_rd_addr),
        .mask_o (clr_mask)
    );

    assign busy_eff   = busy_q & ~clr_mask;
    assign cnt_eff    = {1'b0, cnt_q} - {{CNT_W{1'b0}}, clr};
    assign rd_tracked = id_rd_we && !is_x0(id_rd_addr);

    always_comb begin
        raw  = 1'b0;
        waw  = 1'b0;
        full = 1'b0;
        if (id_valid) begin
            raw  = (id_rs1_used && busy_eff[id_rs1_addr])
                || (id_rs2_used && busy_eff[id_rs2_addr]);
            waw  = rd_tracked && busy_eff[id_rd_addr];
            full = id_long_op && rd_tracked
                && (cnt_eff == (CNT_W + 1)'(MAX_PENDING));
        end
    end

    assign stall_id = raw || waw || full;
    assign id_issue = id_valid && !stall_id && !flush && ex_ready;
    assign set      = id_issue && id_long_op && rd_tracked;

    addr_decoder #(
        .N  (NREGS),
        .AW (REG_ADDR_W)
    ) u_set_dec (
        .en_i   (set),
        .addr_i (id_rd_addr),
        .mask_o (set_mask)
    );

    // Set is applied after clear so a same-cycle reissue keeps the entry.
    always_comb begin
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
        cnt_d     = cnt_q + CNT_W'(set) - CNT_W'(clr);
        err_d     = err_q | wb_bad;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign busy          = busy_q;
    assign pending_count = cnt_q;
    assign err           = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a set-based model:
// the model keeps the set of busy registers and derives the count from it.
module tb_reg_scoreboard;

    localparam int NR   = 32;
    localparam int MAXP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rs1_addr;
    logic       id_rs1_used;
    logic [4:0] id_rs2_addr;
    logic       id_rs2_used;
    logic [4:0] id_rd_addr;
    logic       id_rd_we;
    logic       id_long_op;
    logic       ex_ready;
    logic       flush;
    logic       wb_valid;
    logic [4:0] wb_rd_addr;
    logic       stall_id;
    logic       id_issue;
    logic [31:0] busy;
    logic [2:0] pending_count;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;

    bit m_busy[NR];
    bit m_err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs1_used   (id_rs1_used),
        .id_rs2_addr   (id_rs2_addr),
        .id_rs2_used   (id_rs2_used),
        .id_rd_addr    (id_rd_addr),
        .id_rd_we      (id_rd_we),
        .id_long_op    (id_long_op),
        .ex_ready      (ex_ready),
        .flush         (flush),
        .wb_valid      (wb_valid),
        .wb_rd_addr    (wb_rd_addr),
        .stall_id      (stall_id),
        .id_issue      (id_issue),
        .busy          (busy),
        .pending_count (pending_count),
        .err           (err)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input int rs1, input bit u1,
                         input int rs2, input bit u2, input int rd,
                         input bit we, input bit lng, input bit exr,
                         input bit fl, input bit wbv, input int wbr);
        id_valid    = v;
        id_rs1_addr = 5'(rs1);
        id_rs1_used = u1;
        id_rs2_addr = 5'(rs2);
        id_rs2_used = u2;
        id_rd_addr  = 5'(rd);
        id_rd_we    = we;
        id_long_op  = lng;
        ex_ready    = exr;
        flush       = fl;
        wb_valid    = wbv;
        wb_rd_addr  = 5'(wbr);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    endtask

    function automatic int busy_total();
        int c = 0;
        for (int i = 1; i < NR; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    // Called at a negedge with inputs driven; checks then advances one edge.
    task automatic step();
        bit          rel;
        bit          eff[NR];
        bit          hz;
        bit          iss;
        bit          dst;
        logic [31:0] bv;
        int          inflight;
        #1;
        inflight = busy_total();
        rel = wb_valid && wb_rd_addr != 0 && m_busy[wb_rd_addr];
        eff = m_busy;
        if (rel) eff[wb_rd_addr] = 0;
        dst = id_rd_we && id_rd_addr != 0;
        hz = id_valid && (
               (id_rs1_used && eff[id_rs1_addr])
            || (id_rs2_used && eff[id_rs2_addr])
            || (dst && eff[id_rd_addr])
            || (id_long_op && dst && inflight - int'(rel) == MAXP));
        iss = id_valid && !hz && !flush && ex_ready;
        bv = '0;
        for (int i = 0; i < NR; i++) bv[i] = m_busy[i];
        check("stall_id", 32'(stall_id), 32'(hz));
        check("id_issue", 32'(id_issue), 32'(iss));
        check("busy", busy, bv);
        check("pending_count", 32'(pending_count), 32'(inflight));
        check("err", 32'(err), 32'(m_err));
        @(posedge clk);
        if (rst) begin
            m_busy = '{default: 0};
            m_err  = 0;
        end else begin
            if (wb_valid && !rel) m_err = 1;
            if (rel) m_busy[wb_rd_addr] = 0;
            if (iss && id_long_op && dst) m_busy[id_rd_addr] = 1;
        end
        @(negedge clk);
    endtask

    task automatic long_op(input int rd);
        drive(1, 0, 0, 0, 0, rd, 1, 1, 1, 0, 0, 0);
        step();
    endtask

    task automatic wb_only(input int rd);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, rd);
        step();
    endtask

    initial begin
        int busy_list[$];
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        m_busy = '{default: 0};
        m_err  = 0;
        step();
        rst = 1'b0;
        step();

        // load x5, dependent add waits for its writeback
        long_op(5);
        drive(1, 5, 1, 0, 0, 10, 1, 0, 1, 0, 0, 0);
        step();
        step();
        drive(1, 5, 1, 0, 0, 10, 1, 0, 1, 0, 1, 5);
        step();
        idle();
        step();

        // fill to the limit, fifth stalls, released by a same-cycle wb
        for (int r = 1; r <= 4; r++) long_op(r);
        drive(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 6, 1, 1, 1, 0, 1, 2);
        step();
        wb_only(1);
        wb_only(3);
        wb_only(4);
        wb_only(6);

        // WAW on x7, x0 destinations never tracked
        long_op(7);
        drive(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step();
        long_op(0);
        idle();
        step();
        wb_only(7);

        // flush and ex_ready=0 both suppress the set
        drive(1, 0, 0, 0, 0, 9, 1, 1, 1, 1, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0);
        step();
        idle();
        step();

        // wb and reissue of x3 together, then a stray wb raises err
        long_op(3);
        drive(1, 0, 0, 0, 0, 3, 1, 1, 1, 0, 1, 3);
        step();
        wb_only(8);
        idle();
        step();
        wb_only(3);

        // reset mid-flight drops everything
        long_op(1);
        long_op(2);
        long_op(3);
        rst = 1'b1;
        drive(1, 1, 1, 2, 1, 4, 1, 1, 1, 0, 0, 0);
        step();
        rst = 1'b0;
        step();
        idle();
        step();
        wb_only(4);

        for (int n = 0; n < 3000; n++) begin
            busy_list.delete();
            for (int i = 1; i < NR; i++) if (m_busy[i]) busy_list.push_back(i);
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0,
                  $urandom_range(0, 11), $urandom_range(0, 1),
                  $urandom_range(0, 11), $urandom_range(0, 1),
                  $urandom_range(0, 11), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 9) == 0, 0, 0);
            if ($urandom_range(0, 2) == 0) begin
                wb_valid = 1'b1;
                if (busy_list.size() > 0 && $urandom_range(0, 49) != 0)
                    wb_rd_addr = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
                else
                    wb_rd_addr = 5'($urandom_range(0, 31));
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
